// File: rtl/flex_spi_master_if.sv
// Front-end bus of flex_spi_master: transfer request, per-word configuration and received word.
interface flex_spi_master_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned LEN_W  = 4,
   parameter int unsigned DIV_W  = 8
);
   logic              start_i;
   logic              cpol_i;
   logic              cpha_i;
   logic              lsb_first_i;
   logic              hold_ss_i;
   logic              ss_release_i;
   logic [SEL_W-1:0]  ss_sel_i;
   logic [DIV_W-1:0]  clk_div_i;
   logic [LEN_W-1:0]  xfer_len_i;
   logic [DATA_W-1:0] tx_data_i;
   logic              ready_o;
   logic              busy_o;
   logic [DATA_W-1:0] rx_data_o;
   logic              rx_valid_o;
   logic              done_o;

   modport master (
      output start_i, cpol_i, cpha_i, lsb_first_i, hold_ss_i, ss_release_i,
             ss_sel_i, clk_div_i, xfer_len_i, tx_data_i,
      input  ready_o, busy_o, rx_data_o, rx_valid_o, done_o
   );

   modport slave (
      input  start_i, cpol_i, cpha_i, lsb_first_i, hold_ss_i, ss_release_i,
             ss_sel_i, clk_div_i, xfer_len_i, tx_data_i,
      output ready_o, busy_o, rx_data_o, rx_valid_o, done_o
   );
endinterface

// File: rtl/flex_spi_master.sv
// Parametrised SPI master: programmable SCK divider, CPOL/CPHA, bit order, word length
// and chip-select hold across back-to-back words.
module flex_spi_master #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NUM_SS = 4,
   parameter int unsigned SEL_W  = 2,
   parameter int unsigned LEN_W  = 4,
   parameter int unsigned DIV_W  = 8
) (
   input  logic               clk,
   input  logic               rst,
   flex_spi_master_if.slave   bus,
   output logic [NUM_SS-1:0]  ss_n_o,
   output logic               sck_o,
   output logic               mosi_o,
   input  logic               miso_i
);
   localparam int unsigned CNT_W = DIV_W + 1;
   localparam int unsigned TOG_W = LEN_W + 1;
   localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_TAIL, S_HOLD, S_GAP} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TOG_W-1:0]  tog_q, tog_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [DATA_W-1:0] tx_q, tx_d, rxs_q, rxs_d, rx_q, rx_d;
   logic [NUM_SS-1:0] ss_n_q, ss_n_d;
   logic cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, hold_q, hold_d;
   logic sck_q, sck_d, mosi_q, mosi_d, done_q, done_d, busy_q, busy_d, ready_q, ready_d;

   logic              accept_c, half_end_c, sample_c, first_bit_c;
   logic [LEN_W-1:0]  len_in_c, kb_c, kn_c;
   logic [TOG_W-1:0]  tog_last_c;

   // Bit position of the k-th serial bit within the right-justified word.
   function automatic logic [IDX_W-1:0] pos(input logic [LEN_W-1:0] k, input logic lsb,
                                            input logic [LEN_W-1:0] len);
      return lsb ? IDX_W'(k) : IDX_W'(len - k - LEN_W'(1));
   endfunction

   function automatic logic [NUM_SS-1:0] ss_decode(input logic [SEL_W-1:0] sel);
      logic [NUM_SS-1:0] v;
      v = '1;
      for (int unsigned i = 0; i < NUM_SS; i++) begin
         if (sel == SEL_W'(i)) v[i] = 1'b0;
      end
      return v;
   endfunction

   assign accept_c    = bus.start_i & ready_q;
   assign half_end_c  = (cnt_q == CNT_W'(div_q));
   assign len_in_c    = (bus.xfer_len_i == '0 || 32'(bus.xfer_len_i) > DATA_W)
                        ? LEN_W'(DATA_W) : bus.xfer_len_i;
   assign first_bit_c = bus.tx_data_i[pos('0, bus.lsb_first_i, len_in_c)];
   assign tog_last_c  = {len_q, 1'b0} - TOG_W'(1);
   assign kb_c        = tog_q[TOG_W-1:1];
   assign kn_c        = kb_c + LEN_W'(1);
   // Even toggle count means the upcoming SCK edge is a leading edge.
   assign sample_c    = cpha_q ? tog_q[0] : ~tog_q[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;  cnt_q  <= '0;  tog_q  <= '0;  div_q <= '0;
         len_q   <= '0;      sel_q  <= '0;  tx_q   <= '0;  rxs_q <= '0;
         rx_q    <= '0;      ss_n_q <= '1;  cpol_q <= 1'b0; cpha_q <= 1'b0;
         lsb_q   <= 1'b0;    hold_q <= 1'b0; sck_q <= 1'b0; mosi_q <= 1'b0;
         done_q  <= 1'b0;    busy_q <= 1'b0; ready_q <= 1'b0;
      end else begin
         state_q <= state_d; cnt_q  <= cnt_d;  tog_q  <= tog_d;  div_q <= div_d;
         len_q   <= len_d;   sel_q  <= sel_d;  tx_q   <= tx_d;   rxs_q <= rxs_d;
         rx_q    <= rx_d;    ss_n_q <= ss_n_d; cpol_q <= cpol_d; cpha_q <= cpha_d;
         lsb_q   <= lsb_d;   hold_q <= hold_d; sck_q  <= sck_d;  mosi_q <= mosi_d;
         done_q  <= done_d;  busy_q <= busy_d; ready_q <= ready_d;
      end
   end

   always_comb begin
      state_d = state_q; cnt_d = cnt_q + CNT_W'(1); tog_d = tog_q; div_d = div_q;
      len_d = len_q; sel_d = sel_q; tx_d = tx_q; rxs_d = rxs_q; rx_d = rx_q;
      ss_n_d = ss_n_q; cpol_d = cpol_q; cpha_d = cpha_q; lsb_d = lsb_q; hold_d = hold_q;
      sck_d = sck_q; mosi_d = mosi_q; done_d = 1'b0;

      // Per-word fields reload on every accepted start, from IDLE or HOLD.
      if (accept_c) begin
         tx_d   = bus.tx_data_i;
         len_d  = len_in_c;
         lsb_d  = bus.lsb_first_i;
         hold_d = bus.hold_ss_i;
         rxs_d  = '0;
         tog_d  = '0;
      end

      case (state_q)
         S_IDLE: begin
            cnt_d  = '0;
            sck_d  = cpol_q;
            mosi_d = 1'b0;
            if (accept_c) begin
               cpol_d  = bus.cpol_i;
               cpha_d  = bus.cpha_i;
               sel_d   = bus.ss_sel_i;
               div_d   = bus.clk_div_i;
               sck_d   = bus.cpol_i;
               ss_n_d  = ss_decode(bus.ss_sel_i);
               mosi_d  = bus.cpha_i ? 1'b0 : first_bit_c;
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (half_end_c) begin
               cnt_d   = '0;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (half_end_c) begin
               cnt_d = '0;
               sck_d = ~sck_q;
               tog_d = tog_q + TOG_W'(1);
               if (sample_c) begin
                  rxs_d[pos(kb_c, lsb_q, len_q)] = miso_i;
               end else if (cpha_q) begin
                  mosi_d = tx_q[pos(kb_c, lsb_q, len_q)];
               end else if (kn_c < len_q) begin
                  mosi_d = tx_q[pos(kn_c, lsb_q, len_q)];
               end
               if (tog_q == tog_last_c) state_d = S_TAIL;
            end
         end
         S_TAIL: begin
            if (half_end_c) begin
               cnt_d  = '0;
               done_d = 1'b1;
               rx_d   = rxs_q;
               mosi_d = 1'b0;
               if (hold_q) begin
                  state_d = S_HOLD;
               end else begin
                  ss_n_d  = '1;
                  state_d = S_GAP;
               end
            end
         end
         S_HOLD: begin
            cnt_d  = '0;
            mosi_d = 1'b0;
            if (accept_c) begin
               mosi_d  = cpha_q ? 1'b0 : first_bit_c;
               state_d = S_XFER;
            end else if (bus.ss_release_i) begin
               ss_n_d  = '1;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (half_end_c) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
      busy_d  = (state_d != S_IDLE);
   end

   assign bus.ready_o    = ready_q;
   assign bus.busy_o     = busy_q;
   assign bus.rx_data_o  = rx_q;
   assign bus.rx_valid_o = done_q;
   assign bus.done_o     = done_q;
   assign ss_n_o         = ss_n_q;
   assign sck_o          = sck_q;
   assign mosi_o         = mosi_q;
endmodule

// File: tb/tb_flex_spi_master.sv
// Directed bench for flex_spi_master: driver pushes expected words and done cycles into a
// scoreboard, a negedge monitor pops and compares on every done pulse.
module tb_flex_spi_master;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned NUM_SS = 4;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned LEN_W  = 4;
   localparam int unsigned DIV_W  = 8;

   typedef struct {
      logic [7:0] rx;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [NUM_SS-1:0] ss_n;
   logic sck, mosi, miso;
   logic loop, miso_k;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   exp_t sb[$];

   logic        cpol_tb = 1'b0;
   logic        sck_prev = 1'b0;
   int          lead_cnt = 0;
   logic [15:0] mlog = '0;
   logic        watch_en = 1'b0;
   logic [3:0]  watch_ss = 4'hF;
   int          ss_bad = 0;

   flex_spi_master_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .LEN_W(LEN_W), .DIV_W(DIV_W)) bus ();

   flex_spi_master #(.DATA_W(DATA_W), .NUM_SS(NUM_SS), .SEL_W(SEL_W), .LEN_W(LEN_W),
                     .DIV_W(DIV_W)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .ss_n_o(ss_n), .sck_o(sck), .mosi_o(mosi), .miso_i(miso)
   );

   assign miso = loop ? mosi : miso_k;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: SCK leading-edge logger, chip-select watcher and scoreboard checker.
   always @(negedge clk) begin
      if (sck !== sck_prev && sck !== cpol_tb) begin
         lead_cnt <= lead_cnt + 1;
         mlog     <= {mlog[14:0], mosi};
      end
      sck_prev <= sck;
      if (watch_en && ss_n !== watch_ss) ss_bad <= ss_bad + 1;
      if (bus.done_o === 1'b1 || bus.rx_valid_o === 1'b1) begin
         chk("rx_valid_with_done", 32'(bus.rx_valid_o), 32'(bus.done_o));
      end
      if (bus.done_o === 1'b1) begin
         chk("done_expected", 32'(sb.size() != 0), 32'(1));
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("rx_data", 32'(bus.rx_data_o), 32'(e.rx));
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic wait_ready(output int rc);
      int w;
      w = 0;
      while (bus.ready_o !== 1'b1 && w < 4000) begin
         @(negedge clk);
         w++;
      end
      chk("ready_wait", 32'(bus.ready_o), 32'(1));
      rc = cyc;
   endtask

   task automatic do_word(input logic [7:0] tx, input logic [3:0] len, input logic lsb,
                          input logic hold, input logic cp, input logic ch,
                          input logic [2:0] sel, input logic [7:0] div, input logic [7:0] exp_rx,
                          input int lat, input logic expect_done, output int e0);
      int rc;
      wait_ready(rc);
      bus.tx_data_i   = tx;
      bus.xfer_len_i  = len;
      bus.lsb_first_i = lsb;
      bus.hold_ss_i   = hold;
      bus.cpol_i      = cp;
      bus.cpha_i      = ch;
      bus.ss_sel_i    = sel;
      bus.clk_div_i   = div;
      cpol_tb         = cp;
      bus.start_i     = 1'b1;
      @(negedge clk);
      bus.start_i     = 1'b0;
      e0              = cyc;
      if (expect_done) sb.push_back('{rx: exp_rx, cyc: e0 + lat});
   endtask

   initial begin
      int e0, e1, rc, lb, sb0, w;
      rst = 1'b1; loop = 1'b1; miso_k = 1'b0;
      bus.start_i = 1'b0; bus.cpol_i = 1'b0; bus.cpha_i = 1'b0; bus.lsb_first_i = 1'b0;
      bus.hold_ss_i = 1'b0; bus.ss_release_i = 1'b0; bus.ss_sel_i = '0;
      bus.clk_div_i = '0; bus.xfer_len_i = '0; bus.tx_data_i = '0;
      repeat (3) @(negedge clk);
      chk("rst_ss_n", 32'(ss_n), 32'(4'hF));
      chk("rst_sck", 32'(sck), 32'(0));
      chk("rst_mosi", 32'(mosi), 32'(0));
      chk("rst_busy", 32'(bus.busy_o), 32'(0));
      chk("rst_done", 32'(bus.done_o), 32'(0));
      chk("rst_rx_data", 32'(bus.rx_data_o), 32'(0));
      chk("rst_ready", 32'(bus.ready_o), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      // Mode 0, MSB-first, D=0, loopback 0xA5.
      lb = lead_cnt;
      do_word(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'hA5, 18, 1'b1, e0);
      chk("t1_ss_n", 32'(ss_n), 32'(4'hE));
      chk("t1_busy", 32'(bus.busy_o), 32'(1));
      wait_ready(rc);
      chk("t1_ready_edge", 32'(rc - e0), 32'(19));
      chk("t1_lead_edges", 32'(lead_cnt - lb), 32'(8));
      chk("t1_mosi_bits", 32'(mlog[7:0]), 32'(8'hA5));
      chk("t1_ss_idle", 32'(ss_n), 32'(4'hF));

      // Mode 3, LSB-first, D=2, L=4, miso tied high.
      loop = 1'b0; miso_k = 1'b1;
      lb = lead_cnt;
      do_word(8'h09, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 8'd2, 8'h0F, 30, 1'b1, e0);
      chk("t2_sck_idle_high", 32'(sck), 32'(1));
      wait_ready(rc);
      chk("t2_lead_edges", 32'(lead_cnt - lb), 32'(4));
      chk("t2_mosi_bits", 32'(mlog[3:0]), 32'(4'h9));
      loop = 1'b1;

      // Held chip select across two words, then release.
      do_word(8'h3C, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1, 8'h3C, 36, 1'b1, e0);
      sb0 = ss_bad; watch_ss = 4'hB; watch_en = 1'b1;
      do_word(8'hC3, 4'd8, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1, 8'hC3, 34, 1'b1, e1);
      wait_ready(rc);
      chk("t3_second_done_lat", 32'(rc - e1), 32'(34));
      chk("t3_hold_ss_n", 32'(ss_n), 32'(4'hB));
      watch_en = 1'b0;
      chk("t3_ss_continuous", 32'(ss_bad - sb0), 32'(0));
      bus.ss_release_i = 1'b1;
      @(negedge clk);
      bus.ss_release_i = 1'b0;
      chk("t3_release_ss_n", 32'(ss_n), 32'(4'hF));
      chk("t3_release_ready", 32'(bus.ready_o), 32'(0));
      repeat (2) @(negedge clk);
      chk("t3_ready_after_gap", 32'(bus.ready_o), 32'(1));

      // Reset during bit 3, then a clean word.
      do_word(8'hFF, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd0, 8'h00, 0, 1'b0, e0);
      repeat (8) @(negedge clk);
      chk("t4_mid_busy", 32'(bus.busy_o), 32'(1));
      rst = 1'b1;
      @(negedge clk);
      chk("t4_abort_ss_n", 32'(ss_n), 32'(4'hF));
      chk("t4_abort_sck", 32'(sck), 32'(0));
      chk("t4_abort_busy", 32'(bus.busy_o), 32'(0));
      chk("t4_abort_rx_data", 32'(bus.rx_data_o), 32'(0));
      rst = 1'b0;
      do_word(8'h5A, 4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0, 8'h5A, 18, 1'b1, e0);
      chk("t4_ss_n_sel1", 32'(ss_n), 32'(4'hD));
      wait_ready(rc);

      // xfer_len=0 means full width; start while busy is ignored.
      lb = lead_cnt;
      do_word(8'h81, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'd1, 8'h81, 36, 1'b1, e0);
      repeat (4) @(negedge clk);
      bus.tx_data_i = 8'hFF; bus.hold_ss_i = 1'b1; bus.start_i = 1'b1;
      @(negedge clk);
      bus.start_i = 1'b0; bus.hold_ss_i = 1'b0;
      wait_ready(rc);
      chk("t5_len0_edges", 32'(lead_cnt - lb), 32'(8));
      chk("t5_ready_edge", 32'(rc - e0), 32'(38));

      // Out-of-range select: no chip select, word still completes.
      sb0 = ss_bad; watch_ss = 4'hF; watch_en = 1'b1;
      do_word(8'h3C, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 3'd5, 8'd0, 8'h3C, 18, 1'b1, e0);
      wait_ready(rc);
      watch_en = 1'b0;
      chk("t5_sel5_ss_high", 32'(ss_bad - sb0), 32'(0));

      w = 0;
      while (sb.size() != 0 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("scoreboard_empty", 32'(sb.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
